// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor: opcodes, the NOP word and
// the fetch-stage state encoding.
package proc_pkg;

  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [4:0]  OP_NOP    = 5'b00001;
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  // Fetch sequencing: ISSUE sends a read, WAIT holds until the memory
  // answers, HOLD presents the word to decode, HALTED parks after HALT.
  typedef enum logic [1:0] {
    ISSUE  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/reg16_en.sv
// 16-bit register with synchronous active-high reset to RST_VAL and a
// load enable.
module reg16_en #(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Next value: load when enabled, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  // Register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) q_q <= RST_VAL;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one read at a time to a
// variable-latency instruction memory, and holds the fetched word for
// decode under valid/ready. Handles redirects and HALT.
//
// Handshake: decode takes the word in any cycle where instr_valid and
// instr_ready are both 1; instr, instr_pc and pc_plus2 do not change while
// instr_valid=1 and instr_ready=0. On the memory side mem_req is a
// one-cycle pulse and exactly one mem_done answers each request.
module fetch_stage
  import proc_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [4:0]  HALT_OPCODE = OP_HALT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_done,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] RESET_PC_ALIGNED = {RESET_PC[15:1], 1'b0};

  fetch_state_e state_q, state_d;
  logic         squash_q, squash_d;
  logic         instr_valid_q, instr_valid_d;
  logic         halted_q, halted_d;

  logic [15:0]  pc_q, pc_d, pc_inc;
  logic         pc_en;
  logic         cap_en;
  logic         accept;

  assign pc_inc = pc_q + 16'd2;
  assign accept = (state_q == HOLD) & instr_ready;

  // The request is suppressed in the cycle a redirect arrives so the old
  // PC is never fetched.
  assign mem_req  = (state_q == ISSUE) & ~rst & ~redirect;
  assign mem_addr = pc_q;

  // Next-state, squash, valid, halt and PC/capture enables.
  always_comb begin
    state_d       = state_q;
    squash_d      = squash_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    pc_d          = pc_inc;
    pc_en         = 1'b0;
    cap_en        = 1'b0;
    if (redirect) begin
      pc_d  = redirect_pc & 16'hFFFE;
      pc_en = 1'b1;
      unique case (state_q)
        ISSUE: state_d = ISSUE;
        WAIT: begin
          if (mem_done) begin
            // Response in the redirect cycle is for the old path: drop it.
            squash_d = 1'b0;
            state_d  = ISSUE;
          end else begin
            squash_d = 1'b1;
          end
        end
        HOLD: begin
          instr_valid_d = 1'b0;
          state_d       = ISSUE;
        end
        HALTED: begin
          halted_d = 1'b0;
          state_d  = ISSUE;
        end
        default: state_d = ISSUE;
      endcase
    end else begin
      unique case (state_q)
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (mem_done) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = ISSUE;
            end else begin
              cap_en        = 1'b1;
              pc_en         = 1'b1;
              instr_valid_d = 1'b1;
              state_d       = HOLD;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            instr_valid_d = 1'b0;
            if (instr[15:11] == HALT_OPCODE) begin
              halted_d = 1'b1;
              state_d  = HALTED;
            end else begin
              state_d = ISSUE;
            end
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = ISSUE;
      endcase
    end
  end

  // Control flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ISSUE;
      squash_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      squash_q      <= squash_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  reg16_en #(.RST_VAL(RESET_PC_ALIGNED)) u_pc (
    .clk (clk), .rst (rst), .en (pc_en), .d (pc_d), .q (pc_q)
  );

  reg16_en #(.RST_VAL(NOP_INSTR)) u_instr (
    .clk (clk), .rst (rst), .en (cap_en), .d (mem_data), .q (instr)
  );

  reg16_en #(.RST_VAL(16'h0000)) u_instr_pc (
    .clk (clk), .rst (rst), .en (cap_en), .d (pc_q), .q (instr_pc)
  );

  reg16_en #(.RST_VAL(16'h0000)) u_pc_plus2 (
    .clk (clk), .rst (rst), .en (cap_en), .d (pc_inc), .q (pc_plus2)
  );

  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage for the unpipelined 16-bit processor. Sits directly upstream of decode, which slices immediate fields out of the instruction and passes them to the 5/8/11-bit sign/zero extenders.
- Owns the PC.
- Issues one instruction-memory read at a time against a variable-latency memory.
- Holds the fetched word under a valid/ready handshake.
- Handles branch/jump redirects and HALT.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset; bit 0 must be 0.
HALT_OPCODE, 5'b00000, instr[15:11] value that stops fetch once accepted.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
mem_req  out  1  read request, one-cycle pulse.
mem_addr  out  16  read address; valid while mem_req=1.
mem_done  in  1  response valid, one cycle, at least 1 cycle after mem_req.
mem_data  in  16  instruction word; valid when mem_done=1.
instr  out  16  held instruction.
instr_pc  out  16  address of instr.
pc_plus2  out  16  instr_pc+2, mod 2^16.
instr_valid  out  1  instr/instr_pc/pc_plus2 valid.
instr_ready  in  1  decode accepts when instr_valid & instr_ready.
redirect  in  1  load new PC (taken branch/jump).
redirect_pc  in  16  target; bit 0 forced to 0.
halted  out  1  fetch stopped on HALT.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: pc=RESET_PC, state=ISSUE, squash=0, instr=16'h0800 (NOP), instr_pc=0, pc_plus2=0, instr_valid=0, halted=0. mem_req=0 while rst=1.
- mem_req is combinational: (state==ISSUE) & ~rst & ~redirect. mem_addr=pc at all times. At most one request outstanding.
- ISSUE: mem_req=1 → WAIT next cycle. The first request appears the first cycle rst=0.
- WAIT, mem_done=1, squash=1: drop data, squash←0, → ISSUE.
- WAIT, mem_done=1, squash=0: instr←mem_data, instr_pc←pc, pc_plus2←pc+2, pc←pc+2, instr_valid←1, → HOLD.
- HOLD: outputs stable while instr_ready=0 (no mem_req).
- HOLD, accept, instr[15:11]==HALT_OPCODE: instr_valid←0, halted←1, → HALTED.
- HOLD, accept, otherwise: instr_valid←0, → ISSUE.
- HALTED: no requests; stays there until redirect or rst.
- Redirect (priority below rst, above all else): pc←{redirect_pc[15:1],0}.
  - ISSUE: no mem_req this cycle; stay ISSUE.
  - WAIT without mem_done: squash←1; stay WAIT until the stale response arrives, then ISSUE.
  - WAIT with mem_done same cycle: data dropped, → ISSUE; squash stays 0.
  - HOLD: instr_valid←0, → ISSUE. If instr_ready was also 1, that instruction counts as accepted but HALT is not entered.
  - HALTED: halted←0, → ISSUE.
- Latency: mem_done in cycle N → instr_valid=1 in N+1. Accept in cycle M → mem_req=1 in M+1.
- PC wrap: 16'hFFFE+2 = 16'h0000, both for pc and pc_plus2.
- rst mid-WAIT: state returns to ISSUE with squash=0. Memory is reset alongside, so no stale response arrives.

Decomposition:
- Shared package `proc_pkg`:
  - opcode constants: OP_HALT=5'b00000, OP_NOP=5'b00001;
  - NOP_INSTR=16'h0800;
  - fetch state encoding: ISSUE, WAIT, HOLD, HALTED (2 bits).
- Sub-module `reg16_en`: 16-bit register with synchronous active-high reset value and load enable. Instantiated for pc, instr, instr_pc, pc_plus2.
- FSM and squash flag stay in fetch_stage.

Test Plan:
1. Reset release, mem_done 2 cycles after mem_req with 16'h4A2F → mem_addr=0000; then instr=4A2F, instr_pc=0000, pc_plus2=0002, instr_valid=1; after accept, mem_req with mem_addr=0002.
2. Backpressure: instr_ready=0 for 3 cycles in HOLD → instr/instr_pc constant, mem_req=0; accept on cycle 4 → mem_req next cycle.
3. Redirect to 16'h0041 while WAIT, stale response 16'h1234 arrives 2 cycles later → instr_valid never asserts for 1234; next mem_addr=0040.
4. Redirect to 16'h0100 in the same cycle as mem_done → data dropped, mem_req next cycle with mem_addr=0100, no extra wait for a response.
5. Fetch 16'h0000 (HALT), accept → halted=1, mem_req=0 for 10 cycles; redirect to 16'h0200 → halted=0, mem_req with mem_addr=0200 next cycle.
6. RESET_PC=16'hFFFE: fetch 16'h0800 → pc_plus2=0000, next mem_addr=0000. Assert rst during a later WAIT → all outputs return to reset values, fetch restarts at FFFE.
